onchip_memory_arbiter: RTL and testbench

- Shares the single-port on-chip RAM (14-bit word address, 32-bit data, 4 byte enables) between two Avalon-MM masters: m0 = Nios II data master, m1 = sensor/DMA logger.
- Round-robin arbitration issues at most one RAM access per cycle and stalls the losing master with waitrequest.
- Read data returns on the owning master with readdatavalid after a fixed pipeline latency.
- Sits between the interconnect and the RAM's chipselect/write/address/byteenable/writedata/readdata port.

---
 rtl/onchip_memory_arbiter_pkg.sv | 12 +
 rtl/onchip_memory_arbiter_if.sv | 22 ++
 rtl/onchip_memory_arbiter_rr_arbiter2.sv | 20 ++
 rtl/onchip_memory_arbiter.sv | 64 ++++++
 tb/tb_onchip_memory_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_memory_arbiter_pkg.sv
// onchip_mem_arb_pkg: shared ids, read-pipe entry type and latency check for the RAM arbiter
package onchip_mem_arb_pkg;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    typedef struct packed {
        logic valid;
        logic id;
    } rd_entry_t;
    function automatic bit latency_ok(input int lat);
        return lat == 1 || lat == 2;
    endfunction
endpackage

// File: rtl/onchip_memory_arbiter_if.sv
// onchip_memory_arbiter_if: Avalon-MM master port as seen by the RAM arbiter
interface onchip_memory_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant that remembers the last winner
module rr_arbiter2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic last_grant;
    // a tie goes to the master that did not win last; a lone requester always wins
    always_comb
        grant = &req ? (last_grant == M1 ? 2'b01 : 2'b10) : req;
    // remember the winner only in cycles where somebody was granted
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            last_grant <= M1;
        else if (|grant)
            last_grant <= grant[M1];
endmodule

// File: rtl/onchip_memory_arbiter.sv
// onchip_memory_arbiter: shares one single-port RAM between two Avalon-MM masters
module onchip_memory_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_memory_arbiter_if.slave m0,
    onchip_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    logic [1:0] req;
    logic [1:0] grant;
    logic       rd_accept;
    rd_entry_t [READ_LATENCY-1:0] pipe;
    rd_entry_t  last;
    // requests are ignored while reset is held so nothing is granted and both masters stall
    assign req = {m1.read | m1.write, m0.read | m0.write} & {2{reset_n}};
    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant)
    );
    // steer the granted master onto the RAM port, all zero when nobody is granted
    always_comb begin
        mem_chipselect = |grant;
        mem_write      = grant[M0] ? m0.write : grant[M1] & m1.write;
        mem_address    = grant[M0] ? m0.address : grant[M1] ? m1.address : '0;
        mem_byteenable = grant[M0] ? m0.byteenable : grant[M1] ? m1.byteenable : '0;
        mem_writedata  = grant[M0] ? m0.writedata : grant[M1] ? m1.writedata : '0;
    end
    assign mem_clken = 1'b1;
    // read+write together counts as a write, so only a pure read enters the return pipe
    assign rd_accept = mem_chipselect & ~mem_write;
    // track each accepted read and its owner until the RAM data is due
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            pipe <= '0;
        else begin
            pipe[0] <= '{valid: rd_accept, id: grant[M1]};
            for (int i = 1; i < READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    assign last             = pipe[READ_LATENCY-1];
    assign m0.readdatavalid = last.valid & (last.id == M0);
    assign m1.readdatavalid = last.valid & (last.id == M1);
    assign m0.readdata      = (last.valid & (last.id == M0)) ? mem_readdata : '0;
    assign m1.readdata      = (last.valid & (last.id == M1)) ? mem_readdata : '0;
    assign m0.waitrequest   = ~(req[M0] & grant[M0]);
    assign m1.waitrequest   = ~(req[M1] & grant[M1]);
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// tb_onchip_memory_arbiter: scoreboard bench driving latency-1 and latency-2 arbiters in lockstep
module tb_onchip_memory_arbiter;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [3:0]  wreq_v;
    logic [3:0]  rdv_v;
    logic [1:0]  clken_v;
    logic [31:0] rdata [4];
    logic [1:0]  exp_w;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e;
    int          idx [4];
    int          cyc;
    int          compared;
    int          mismatched;
    bit          done;

    function automatic logic [31:0] pat(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        onchip_memory_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b0 ();
        onchip_memory_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b1 ();
        logic [13:0] mem_address;
        logic [3:0]  mem_byteenable;
        logic        mem_chipselect;
        logic        mem_write;
        logic        mem_clken;
        logic [31:0] mem_writedata;
        logic [31:0] mem_readdata;
        logic [31:0] q_a;
        logic [31:0] q_b;
        logic [31:0] ram [16384];
        bit          written [16384];
        assign b0.address    = addr[0];
        assign b0.byteenable = be[0];
        assign b0.read       = rd[0];
        assign b0.write      = wr[0];
        assign b0.writedata  = wd[0];
        assign b1.address    = addr[1];
        assign b1.byteenable = be[1];
        assign b1.read       = rd[1];
        assign b1.write      = wr[1];
        assign b1.writedata  = wd[1];
        assign wreq_v[2*l+:2] = {b1.waitrequest, b0.waitrequest};
        assign rdv_v[2*l+:2]  = {b1.readdatavalid, b0.readdatavalid};
        assign rdata[2*l]     = b0.readdata;
        assign rdata[2*l+1]   = b1.readdata;
        assign clken_v[l]     = mem_clken;
        onchip_memory_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(l + 1)) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .m0             (b0),
            .m1             (b1),
            .mem_address    (mem_address),
            .mem_byteenable (mem_byteenable),
            .mem_chipselect (mem_chipselect),
            .mem_write      (mem_write),
            .mem_writedata  (mem_writedata),
            .mem_clken      (mem_clken),
            .mem_readdata   (mem_readdata)
        );
        // RAM model: unwritten words read back as a pattern of their address
        always @(posedge clk) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b+:8] <= mem_writedata[8*b+:8];
                written[mem_address] <= 1'b1;
            end
            if (mem_chipselect && !mem_write)
                q_a <= written[mem_address] ? ram[mem_address] : pat(mem_address);
            q_b <= q_a;
        end
        assign mem_readdata = (l == 0) ? q_a : q_b;
    end

    // monitor: checks stalls every cycle and pops read returns against the scoreboard
    always @(negedge clk) begin
        compared++;
        if (wreq_v !== {exp_w, exp_w}) begin
            mismatched++;
            $display("FAIL waitrequest cyc=%0d got=%b want=%b", cyc, wreq_v, {exp_w, exp_w});
        end
        compared++;
        if (clken_v !== 2'b11) begin
            mismatched++;
            $display("FAIL mem_clken cyc=%0d got=%b want=11", cyc, clken_v);
        end
        if (|(rd & wr)) begin
            mismatched++;
            $display("FAIL illegal_read_write cyc=%0d rd=%b wr=%b", cyc, rd, wr);
        end
        for (int k = 0; k < 4; k++) begin
            if (!rdv_v[k]) begin
                compared++;
                if (rdata[k] !== 32'd0) begin
                    mismatched++;
                    $display("FAIL readdata_idle lat%0d m%0d cyc=%0d got=%h want=0", k / 2 + 1, k % 2, cyc, rdata[k]);
                end
            end else if (idx[k] >= ((k % 2 == 1) ? q1.size() : q0.size())) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_strobe lat%0d m%0d cyc=%0d got=%h want=none", k / 2 + 1, k % 2, cyc, rdata[k]);
            end else begin
                if (k % 2 == 1)
                    e = q1[idx[k]];
                else
                    e = q0[idx[k]];
                compared += 2;
                if (rdata[k] !== e.data) begin
                    mismatched++;
                    $display("FAIL readdata lat%0d m%0d cyc=%0d got=%h want=%h", k / 2 + 1, k % 2, cyc, rdata[k], e.data);
                end
                if (cyc != e.cyc + k / 2 + 1) begin
                    mismatched++;
                    $display("FAIL latency lat%0d m%0d got_cyc=%0d want_cyc=%0d", k / 2 + 1, k % 2, cyc, e.cyc + k / 2 + 1);
                end
                idx[k]++;
            end
        end
        if (done) begin
            for (int k = 0; k < 4; k++) begin
                compared++;
                if (idx[k] != ((k % 2 == 1) ? q1.size() : q0.size())) begin
                    mismatched++;
                    $display("FAIL strobe_count lat%0d m%0d got=%0d want=%0d", k / 2 + 1, k % 2, idx[k], (k % 2 == 1) ? q1.size() : q0.size());
                end
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    // one cycle of stimulus: ew is the required {m1,m0} waitrequest, ed the data owed to an accepted read
    task automatic tick(input logic [1:0] ew, input logic [31:0] ed0, input logic [31:0] ed1);
        exp_w = ew;
        if (!ew[0] && rd[0] && !wr[0]) q0.push_back('{ed0, cyc});
        if (!ew[1] && rd[1] && !wr[1]) q1.push_back('{ed1, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd = '0;
        wr = '0;
        for (int i = 0; i < n; i++) tick(2'b11, '0, '0);
    endtask

    initial begin
        rd    = '0;
        wr    = '0;
        addr  = '{default: '0};
        be    = '{default: 4'hF};
        wd    = '{default: '0};
        exp_w = 2'b11;
        @(posedge clk);
        #1;
        rd[0] = 1'b1;
        tick(2'b11, '0, '0);
        tick(2'b11, '0, '0);
        reset_n = 1'b1;
        addr[0] = 14'h0100;
        addr[1] = 14'h0200;
        rd      = 2'b11;
        for (int i = 0; i < 100; i++) begin
            tick((i % 2 == 0) ? 2'b10 : 2'b01, pat(addr[0]), pat(addr[1]));
            if (i % 2 == 0) addr[0]++;
            else addr[1]++;
        end
        idle(3);
        addr[0] = 14'h0010;
        wd[0]   = 32'hDEADBEEF;
        be[0]   = 4'hF;
        wr[0]   = 1'b1;
        tick(2'b10, '0, '0);
        wr[0] = 1'b0;
        rd[0] = 1'b1;
        tick(2'b10, 32'hDEADBEEF, '0);
        idle(3);
        addr[1] = 14'h3FFF;
        wd[1]   = 32'h11223344;
        be[1]   = 4'hF;
        wr[1]   = 1'b1;
        tick(2'b01, '0, '0);
        wd[1] = 32'hAABBCCDD;
        be[1] = 4'h5;
        tick(2'b01, '0, '0);
        wr[1] = 1'b0;
        rd[1] = 1'b1;
        tick(2'b01, '0, 32'h11BB33DD);
        idle(3);
        addr[0] = 14'h0030;
        rd[0]   = 1'b1;
        tick(2'b10, pat(14'h0030), '0);
        addr[0] = 14'h0020;
        addr[1] = 14'h0020;
        wd[1]   = 32'h00000055;
        be[1]   = 4'hF;
        wr[1]   = 1'b1;
        tick(2'b01, '0, '0);
        wr[1] = 1'b0;
        tick(2'b10, 32'h00000055, '0);
        idle(3);
        addr[1] = 14'h0040;
        rd[1]   = 1'b1;
        exp_w   = 2'b01;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rd      = 2'b01;
        tick(2'b11, '0, '0);
        tick(2'b11, '0, '0);
        reset_n = 1'b1;
        idle(3);
        addr[0] = 14'h0050;
        addr[1] = 14'h0060;
        rd      = 2'b11;
        tick(2'b10, pat(14'h0050), '0);
        tick(2'b01, '0, pat(14'h0060));
        rd = 2'b01;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 14'h0070 + 14'(i);
            tick(2'b10, pat(addr[0]), '0);
        end
        idle(4);
        done = 1'b1;
    end
endmodule
